// File: rtl/jtopl_eg_sched.sv
// Slot sequencer for the envelope-generator controller: walks the operator slots,
// holds per-slot EG state and key-on history, runs the global envelope counter.
module jtopl_eg_sched #(
   parameter int SLOTS = 18,
   parameter int CNTW  = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cen,
   input  logic [SLOTS-1:0] keyon,
   input  logic [1:0]       ks,
   input  logic [2:0]       state_next,
   input  logic [4:0]       base_rate,
   output logic [4:0]       slot,
   output logic [2:0]       state_in,
   output logic             keyon_now,
   output logic             keyoff_now,
   output logic [5:0]       rate,
   output logic             step_en,
   output logic [CNTW-1:0]  eg_cnt,
   output logic             sample
);

   localparam logic [4:0] SLOT_LAST = 5'(SLOTS - 1);

   logic [4:0]       slot_q, slot_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;
   logic [2:0]       state_q [SLOTS];
   logic [SLOTS-1:0] prev_q;
   logic             last_slot;

   logic [6:0]       rate_sum;
   logic [3:0]       sh;
   logic [11:0]      step_mask;

   assign last_slot = (slot_q == SLOT_LAST);

   // NOTE: every signal driven here gets a default first so no latch is inferred.
   always_comb begin
      slot_d = slot_q;
      cnt_d  = cnt_q;
      if (cen) begin
         if (last_slot) begin
            slot_d = '0;
            cnt_d  = cnt_q + CNTW'(1);
         end else begin
            slot_d = slot_q + 5'd1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only. The state memory
   // is cleared on reset because a reset must leave every slot in release.
   always_ff @(posedge clk) begin
      if (rst) begin
         slot_q <= '0;
         cnt_q  <= '0;
         prev_q <= '0;
         for (int i = 0; i < SLOTS; i++) state_q[i] <= 3'b000;
      end else begin
         slot_q <= slot_d;
         cnt_q  <= cnt_d;
         if (cen) begin
            state_q[slot_q] <= state_next;
            prev_q[slot_q]  <= keyon[slot_q];
         end
      end
   end

   assign slot       = slot_q;
   assign eg_cnt     = cnt_q;
   assign sample     = last_slot;
   assign state_in   = state_q[slot_q];
   assign keyon_now  =  keyon[slot_q] & ~prev_q[slot_q];
   assign keyoff_now = ~keyon[slot_q] &  prev_q[slot_q];

   // Effective rate: doubled base rate plus key-scale, clamped to the 6-bit range.
   assign rate_sum = {1'b0, base_rate, 1'b0} + {5'd0, ks};

   always_comb begin
      rate = 6'd0;
      if (base_rate != 5'd0) rate = (rate_sum > 7'd63) ? 6'd63 : rate_sum[5:0];
   end

   // Step once every 2^(12-sh) samples; the mask covers eg_cnt[11-sh:0].
   assign sh        = rate[5:2];
   assign step_mask = 12'hFFF >> sh;

   always_comb begin
      step_en = 1'b0;
      if (rate != 6'd0) step_en = (sh >= 4'd12) || ((cnt_q[11:0] & step_mask) == 12'd0);
   end

endmodule

// File: tb/tb_jtopl_eg_sched.sv
// Self-checking bench for jtopl_eg_sched against a per-slot behavioural model.
module tb_jtopl_eg_sched;

   localparam int SLOTS = 18;
   localparam int CNTW  = 15;

   logic             clk = 1'b0;
   logic             rst;
   logic             cen;
   logic [SLOTS-1:0] keyon;
   logic [1:0]       ks;
   logic [2:0]       state_next;
   logic [4:0]       base_rate;
   logic [4:0]       slot;
   logic [2:0]       state_in;
   logic             keyon_now;
   logic             keyoff_now;
   logic [5:0]       rate;
   logic             step_en;
   logic [CNTW-1:0]  eg_cnt;
   logic             sample;

   int checks = 0;
   int errors = 0;

   int       m_slot;
   int       m_cnt;
   logic [2:0] m_state [SLOTS];
   bit       m_prev [SLOTS];

   jtopl_eg_sched #(.SLOTS(SLOTS), .CNTW(CNTW)) dut (
      .clk(clk), .rst(rst), .cen(cen), .keyon(keyon), .ks(ks),
      .state_next(state_next), .base_rate(base_rate), .slot(slot),
      .state_in(state_in), .keyon_now(keyon_now), .keyoff_now(keyoff_now),
      .rate(rate), .step_en(step_en), .eg_cnt(eg_cnt), .sample(sample)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish within time limit");
      $fatal(1);
   end

   function automatic int exp_rate(int br, int k);
      int r;
      if (br == 0) return 0;
      r = 2 * br + k;
      if (r > 63) r = 63;
      return r;
   endfunction

   function automatic bit exp_step(int r, int cnt);
      int sh;
      if (r == 0) return 1'b0;
      sh = r / 4;
      if (sh >= 12) return 1'b1;
      return (cnt % (1 << (12 - sh))) == 0;
   endfunction

   // Advance one clock and update the model with the inputs in force at the edge.
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         m_slot = 0;
         m_cnt  = 0;
         for (int i = 0; i < SLOTS; i++) begin
            m_state[i] = 3'b000;
            m_prev[i]  = 1'b0;
         end
      end else if (cen) begin
         m_state[m_slot] = state_next;
         m_prev[m_slot]  = keyon[m_slot];
         if (m_slot == SLOTS - 1) begin
            m_slot = 0;
            m_cnt  = (m_cnt + 1) % (1 << CNTW);
         end else begin
            m_slot++;
         end
      end
      @(negedge clk);
   endtask

   // Advance with cen until the given slot is current, holding each slot's state.
   task automatic goto_slot(int target);
      cen = 1'b1;
      for (int i = 0; i < SLOTS && m_slot != target; i++) begin
         state_next = m_state[m_slot];
         tick();
      end
      #1;
      checks++;
      if (slot !== 5'(target)) begin
         errors++;
         $display("FAIL goto_slot: slot=%0d expected=%0d", slot, target);
      end
   endtask

   task automatic test_reset();
      rst        = 1'b1;
      cen        = 1'b1;
      keyon      = SLOTS'($urandom) | SLOTS'(1);
      ks         = 2'd0;
      base_rate  = 5'd0;
      state_next = 3'b111;
      tick();
      tick();
      rst = 1'b0;
      cen = 1'b0;
      #1;
      checks++;
      if (slot !== 5'd0) begin errors++; $display("FAIL reset_slot: got %0d expected 0", slot); end
      checks++;
      if (eg_cnt !== '0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", eg_cnt); end
      checks++;
      if (state_in !== 3'b000) begin errors++; $display("FAIL reset_state: got %b expected 000", state_in); end
      checks++;
      if (sample !== 1'b0) begin errors++; $display("FAIL reset_sample: got %b expected 0", sample); end
      checks++;
      if (keyon_now !== 1'b1) begin errors++; $display("FAIL reset_keyon_now: got %b expected 1", keyon_now); end
      checks++;
      if (keyoff_now !== 1'b0) begin errors++; $display("FAIL reset_keyoff_now: got %b expected 0", keyoff_now); end
   endtask

   task automatic test_slot_walk();
      keyon      = '0;
      state_next = 3'b000;
      cen        = 1'b1;
      for (int i = 0; i <= SLOTS; i++) begin
         #1;
         checks++;
         if (slot !== 5'(i % SLOTS)) begin
            errors++; $display("FAIL walk_slot: step %0d got %0d expected %0d", i, slot, i % SLOTS);
         end
         checks++;
         if (sample !== (i == SLOTS - 1)) begin
            errors++; $display("FAIL walk_sample: step %0d got %b", i, sample);
         end
         checks++;
         if (eg_cnt !== CNTW'(i == SLOTS)) begin
            errors++; $display("FAIL walk_cnt: step %0d got %0d expected %0d", i, eg_cnt, i == SLOTS);
         end
         checks++;
         if (state_in !== 3'b000) begin
            errors++; $display("FAIL walk_state: step %0d got %b expected 000", i, state_in);
         end
         if (i < SLOTS) tick();
      end
   endtask

   task automatic test_keyon();
      keyon[5] = 1'b1;
      goto_slot(5);
      state_next = 3'b001;
      checks++;
      if (keyon_now !== 1'b1) begin errors++; $display("FAIL keyon_edge: got %b expected 1", keyon_now); end
      checks++;
      if (keyoff_now !== 1'b0) begin errors++; $display("FAIL keyon_no_off: got %b expected 0", keyoff_now); end
      checks++;
      if (state_in !== 3'b000) begin errors++; $display("FAIL keyon_state0: got %b expected 000", state_in); end
      tick();
      goto_slot(5);
      state_next = 3'b001;
      checks++;
      if (state_in !== 3'b001) begin errors++; $display("FAIL keyon_writeback: got %b expected 001", state_in); end
      checks++;
      if (keyon_now !== 1'b0) begin errors++; $display("FAIL keyon_once: got %b expected 0", keyon_now); end
      tick();
   endtask

   task automatic test_keyoff();
      keyon[5] = 1'b0;
      goto_slot(5);
      state_next = 3'b000;
      checks++;
      if (keyoff_now !== 1'b1) begin errors++; $display("FAIL keyoff_edge: got %b expected 1", keyoff_now); end
      checks++;
      if (keyon_now !== 1'b0) begin errors++; $display("FAIL keyoff_no_on: got %b expected 0", keyon_now); end
      tick();
      for (int s = 0; s < 2; s++) begin
         goto_slot(5);
         state_next = 3'b000;
         checks++;
         if (keyoff_now !== 1'b0) begin
            errors++; $display("FAIL keyoff_once: sample %0d got %b expected 0", s, keyoff_now);
         end
         tick();
      end
   endtask

   task automatic test_rate_slow();
      int hits;
      hits      = 0;
      base_rate = 5'd4;
      ks        = 2'd1;
      cen       = 1'b1;
      #1;
      checks++;
      if (rate !== 6'd9) begin errors++; $display("FAIL slow_rate: got %0d expected 9", rate); end
      for (int s = 0; s < 2048; s++) begin
         for (int k = 0; k < SLOTS; k++) begin
            state_next = m_state[m_slot];
            #1;
            if (m_slot == 0) begin
               checks++;
               if (step_en !== exp_step(9, m_cnt)) begin
                  errors++; $display("FAIL slow_step: cnt=%0d got %b expected %b", m_cnt, step_en, exp_step(9, m_cnt));
               end
               if (step_en === 1'b1) hits++;
            end
            tick();
         end
      end
      checks++;
      if (hits != 2) begin errors++; $display("FAIL slow_hits: got %0d expected 2", hits); end
   endtask

   task automatic test_rate_edges();
      cen = 1'b1;
      for (int pass = 0; pass < 2; pass++) begin
         base_rate = (pass == 0) ? 5'd31 : 5'd0;
         ks        = 2'd3;
         for (int c = 0; c < 2 * SLOTS; c++) begin
            state_next = m_state[m_slot];
            #1;
            checks++;
            if (rate !== 6'(exp_rate(base_rate, 3))) begin
               errors++; $display("FAIL edge_rate: br=%0d got %0d expected %0d", base_rate, rate, exp_rate(base_rate, 3));
            end
            checks++;
            if (step_en !== (pass == 0)) begin
               errors++; $display("FAIL edge_step: br=%0d got %b expected %b", base_rate, step_en, pass == 0);
            end
            tick();
         end
      end
   endtask

   task automatic test_random();
      int  b;
      int  er;
      bit  ek_on;
      bit  ek_off;
      for (int c = 0; c < 1500; c++) begin
         cen = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 2) == 0) begin
            b = $urandom_range(0, SLOTS - 1);
            keyon[b] = ~keyon[b];
         end
         ks        = 2'($urandom);
         base_rate = 5'($urandom);
         case ($urandom_range(0, 3))
            0:       state_next = 3'b000;
            1:       state_next = 3'b001;
            2:       state_next = 3'b010;
            default: state_next = 3'b100;
         endcase
         #1;
         er     = exp_rate(base_rate, ks);
         ek_on  =  keyon[m_slot] && !m_prev[m_slot];
         ek_off = !keyon[m_slot] &&  m_prev[m_slot];
         checks++;
         if (slot !== 5'(m_slot)) begin errors++; $display("FAIL rnd_slot: c=%0d got %0d expected %0d", c, slot, m_slot); end
         checks++;
         if (eg_cnt !== CNTW'(m_cnt)) begin errors++; $display("FAIL rnd_cnt: c=%0d got %0d expected %0d", c, eg_cnt, m_cnt); end
         checks++;
         if (sample !== (m_slot == SLOTS - 1)) begin errors++; $display("FAIL rnd_sample: c=%0d got %b", c, sample); end
         checks++;
         if (state_in !== m_state[m_slot]) begin
            errors++; $display("FAIL rnd_state: c=%0d got %b expected %b", c, state_in, m_state[m_slot]);
         end
         checks++;
         if (keyon_now !== ek_on) begin errors++; $display("FAIL rnd_keyon: c=%0d got %b expected %b", c, keyon_now, ek_on); end
         checks++;
         if (keyoff_now !== ek_off) begin errors++; $display("FAIL rnd_keyoff: c=%0d got %b expected %b", c, keyoff_now, ek_off); end
         checks++;
         if (rate !== 6'(er)) begin errors++; $display("FAIL rnd_rate: c=%0d got %0d expected %0d", c, rate, er); end
         checks++;
         if (step_en !== exp_step(er, m_cnt)) begin
            errors++; $display("FAIL rnd_step: c=%0d got %b expected %b", c, step_en, exp_step(er, m_cnt));
         end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      keyon = '1;
      cen   = 1'b1;
      goto_slot(0);
      for (int k = 0; k < SLOTS; k++) begin
         state_next = 3'b010;
         tick();
      end
      goto_slot(9);
      rst = 1'b1;
      tick();
      rst   = 1'b0;
      keyon = '0;
      #1;
      checks++;
      if (slot !== 5'd0) begin errors++; $display("FAIL midrst_slot: got %0d expected 0", slot); end
      checks++;
      if (eg_cnt !== '0) begin errors++; $display("FAIL midrst_cnt: got %0d expected 0", eg_cnt); end
      for (int k = 0; k < SLOTS; k++) begin
         state_next = 3'b000;
         #1;
         checks++;
         if (state_in !== 3'b000) begin errors++; $display("FAIL midrst_state: slot %0d got %b expected 000", k, state_in); end
         checks++;
         if (keyoff_now !== 1'b0) begin errors++; $display("FAIL midrst_keyoff: slot %0d got %b expected 0", k, keyoff_now); end
         tick();
      end
   endtask

   initial begin
      rst        = 1'b1;
      cen        = 1'b0;
      keyon      = '0;
      ks         = 2'd0;
      state_next = 3'b000;
      base_rate  = 5'd0;
      @(negedge clk);
      test_reset();
      test_slot_walk();
      test_keyon();
      test_keyoff();
      test_rate_slow();
      test_rate_edges();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/jtopl_eg_sched.md
Name: jtopl_eg_sched

Overview:
Time-multiplexed sequencer for the envelope-generator state controller.
- Walks 18 operator slots, one per `cen` pulse.
- For each slot it presents the stored envelope state and the key-on/key-off edge flags to the combinational EG control logic.
- It writes the returned next state back into per-slot storage.
- It runs the global envelope counter and decides whether the current slot's envelope steps this sample, so the downstream attenuation stage only applies the step.

Parameters:
- SLOTS, 18, number of operator slots sequenced (2..32).
- CNTW, 15, global envelope counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cen  in  1  slot-advance enable; all state changes only when cen=1.
- keyon  in  SLOTS  per-slot key-on register bits from the register file.
- ks  in  2  key-scale rate offset for the current slot, valid with `slot`.
- state_next  in  3  next state from EG control for the current slot.
- base_rate  in  5  base rate from EG control for the current slot.
- slot  out  5  current slot index.
- state_in  out  3  stored state of current slot (001 attack, 010 decay, 100 hold, 000 release).
- keyon_now  out  1  rising edge of keyon[slot].
- keyoff_now  out  1  falling edge of keyon[slot].
- rate  out  6  effective rate of current slot.
- step_en  out  1  envelope of current slot advances this sample.
- eg_cnt  out  CNTW  global envelope counter.
- sample  out  1  high while slot==SLOTS-1 (last slot of a sample).

Behaviour:
- One clock, synchronous active-high reset. All outputs are combinational from registered state plus current inputs; there are no extra pipeline stages.
- Reset values:
  - slot=0, eg_cnt=0.
  - All state memory = 000 (release).
  - All prev-keyon bits = 0.
  - Hence keyon_now=keyon[0], keyoff_now=0, state_in=000, sample=0.
- Reset wins over cen. Reset mid-sample discards the partial sample and restarts at slot 0.
- Slot counter: on cen, slot <= (slot==SLOTS-1) ? 0 : slot+1.
- eg_cnt: on cen with slot==SLOTS-1, eg_cnt <= eg_cnt+1, wrapping modulo 2^CNTW. eg_cnt is constant for all slots within one sample.
- Edge flags:
  - keyon_now = keyon[slot] & ~prev[slot].
  - keyoff_now = ~keyon[slot] & prev[slot].
  - Never both high.
- Write-back on cen: state_mem[slot] <= state_next and prev[slot] <= keyon[slot], both in the same cycle. The value presented next visit of this slot is the one written now.
- A keyon change between visits of a slot is seen once, at that slot's visit. A pulse shorter than one sample that returns to the old level produces no edge (level sampled only at visit).
- Rate arithmetic:
  - r = {base_rate,1'b0} + ks, 7-bit sum saturated to 63.
  - rate = (base_rate==0) ? 0 : r[5:0].
- Step decision, with sh = rate[5:2]:
  - rate==0 → step_en=0.
  - sh>=12 → step_en=1 every sample.
  - Otherwise step_en = (eg_cnt[11-sh:0]==0), i.e. once every 2^(12-sh) samples.
  - step_en is only meaningful when cen=1; downstream qualifies it with cen.
- cen=0: nothing changes, outputs hold (inputs may still alter the combinational outputs).

Test Plan:
- Reset, then 18 cen pulses → slot steps 0..17 and wraps to 0; sample high only at slot 17; eg_cnt 0→1 at the wrap; all state_in=000.
- keyon[5] set before slot 5 visit, state_next=001 fed back → at slot 5 keyon_now=1; next sample slot 5 shows state_in=001 and keyon_now=0.
- Clear keyon[5] → keyoff_now=1 exactly once at slot 5, then 0 on later samples.
- base_rate=5'd4 (arate=2), ks=1 → rate=9, sh=2; over 2048 samples step_en is high only where eg_cnt[9:0]==0, i.e. 2 hits.
- base_rate=5'd31, ks=3 → rate=63 (saturated), step_en=1 every sample. base_rate=0, ks=3 → rate=0, step_en=0.
- Assert rst at slot 9 with states stored → next cycle slot=0, eg_cnt=0, all state_in=000, no keyoff_now pulses on subsequent samples.
